// File: rtl/ysyx_25040111_arbiter_if.sv
// AXI4-Lite read address/data channel bundle used for the IFU, LSU and downstream ports
// of the ysyx_25040111_arbiter read arbiter.
interface ysyx_25040111_arbiter_if;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        output arvalid, araddr, arsize, rready,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        input  arvalid, araddr, arsize, rready,
        output arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/ysyx_25040111_arbiter.sv
// Two-master (IFU, LSU) to one-slave AXI4-Lite read arbiter, one outstanding transaction.
// Define ARB_ROUND_ROBIN_EN to break IDLE ties toward the master not granted last.
module ysyx_25040111_arbiter #(
    parameter int TIMEOUT_CYC = 1023,
    parameter int CNT_W       = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ysyx_25040111_arbiter_if.slave  ifu,
    ysyx_25040111_arbiter_if.slave  lsu,
    ysyx_25040111_arbiter_if.master out
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } state_e;

    localparam bit               TMO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(TIMEOUT_CYC - 1) : {CNT_W{1'b0}};

    state_e           r_state;
    logic             r_gnt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tmo;

    logic             w_pick_lsu;
    logic             w_g_arvalid;
    logic [31:0]      w_g_araddr;
    logic [2:0]       w_g_arsize;
    logic             w_g_rready;
    logic             w_arready;
    logic             w_rvalid;
    logic [31:0]      w_rdata;
    logic [1:0]       w_rresp;
    logic             w_ar_hs;
    logic             w_r_hs;
    logic             w_tmo_hit;

    assign w_g_arvalid = r_gnt ? lsu.arvalid : ifu.arvalid;
    assign w_g_araddr  = r_gnt ? lsu.araddr  : ifu.araddr;
    assign w_g_arsize  = r_gnt ? lsu.arsize  : ifu.arsize;
    assign w_g_rready  = r_gnt ? lsu.rready  : ifu.rready;

    assign w_ar_hs   = out.arvalid & out.arready;
    assign w_r_hs    = out.rvalid & out.rready;
    assign w_tmo_hit = TMO_EN && (r_cnt == TMO_LAST) && !out.rvalid;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last;

    assign w_pick_lsu = (lsu.arvalid && ifu.arvalid) ? ~r_last : lsu.arvalid;

    // Last-grant bit starts at LSU so the first tie after reset goes to IFU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (r_state == S_IDLE && (lsu.arvalid || ifu.arvalid)) begin
            r_last <= w_pick_lsu;
        end
    end
`else
    assign w_pick_lsu = lsu.arvalid;
`endif

    // Arbitration FSM, R-phase timeout counter and forced-DECERR flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_gnt   <= 1'b0;
            r_cnt   <= {CNT_W{1'b0}};
            r_tmo   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tmo <= 1'b0;
                    if (lsu.arvalid || ifu.arvalid) begin
                        r_gnt   <= w_pick_lsu;
                        r_state <= S_AR;
                    end
                end
                S_AR: begin
                    if (w_ar_hs) begin
                        r_state <= S_R;
                        r_cnt   <= {CNT_W{1'b0}};
                        r_tmo   <= 1'b0;
                    end
                end
                S_R: begin
                    if (r_tmo ? w_g_rready : w_r_hs) begin
                        r_state <= S_IDLE;
                        r_tmo   <= 1'b0;
                    end else begin
                        if (r_cnt != {CNT_W{1'b1}}) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                        if (w_tmo_hit) begin
                            r_tmo <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tmo   <= 1'b0;
                end
            endcase
        end
    end

    // Route the granted master to the downstream port; IDLE soaks up stray beats.
    always_comb begin
        out.arvalid = 1'b0;
        out.araddr  = 32'h0;
        out.arsize  = 3'h0;
        out.rready  = 1'b0;
        w_arready   = 1'b0;
        w_rvalid    = 1'b0;
        w_rdata     = 32'h0;
        w_rresp     = 2'b00;
        case (r_state)
            S_IDLE: begin
                out.rready = 1'b1;
            end
            S_AR: begin
                out.arvalid = w_g_arvalid;
                out.araddr  = w_g_araddr;
                out.arsize  = w_g_arsize;
                w_arready   = out.arready;
            end
            S_R: begin
                if (r_tmo) begin
                    w_rvalid = 1'b1;
                    w_rresp  = 2'b11;
                end else begin
                    out.rready = w_g_rready;
                    w_rvalid   = out.rvalid;
                    w_rdata    = out.rdata;
                    w_rresp    = out.rresp;
                end
            end
            default: begin
                out.rready = 1'b1;
            end
        endcase
    end

    assign ifu.arready = w_arready & ~r_gnt;
    assign ifu.rvalid  = w_rvalid & ~r_gnt;
    assign ifu.rdata   = r_gnt ? 32'h0 : w_rdata;
    assign ifu.rresp   = r_gnt ? 2'b00 : w_rresp;

    assign lsu.arready = w_arready & r_gnt;
    assign lsu.rvalid  = w_rvalid & r_gnt;
    assign lsu.rdata   = r_gnt ? w_rdata : 32'h0;
    assign lsu.rresp   = r_gnt ? w_rresp : 2'b00;
endmodule

// File: tb/tb_ysyx_25040111_arbiter.sv
// Scenario-driven bench for ysyx_25040111_arbiter: expected read responses are queued when a
// request is launched and popped when the granted master sees its R beat.
module tb_ysyx_25040111_arbiter;
    typedef struct packed {
        logic        m;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    ysyx_25040111_arbiter_if ifu_if();
    ysyx_25040111_arbiter_if lsu_if();
    ysyx_25040111_arbiter_if out_if();

    ysyx_25040111_arbiter #(
        .TIMEOUT_CYC(8),
        .CNT_W      (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ifu  (ifu_if),
        .lsu  (lsu_if),
        .out  (out_if)
    );

    always #5 clk = ~clk;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        ifu_if.arvalid = 1'b0; ifu_if.araddr = 32'h0; ifu_if.arsize = 3'd0; ifu_if.rready = 1'b0;
        lsu_if.arvalid = 1'b0; lsu_if.araddr = 32'h0; lsu_if.arsize = 3'd0; lsu_if.rready = 1'b0;
        out_if.arready = 1'b0; out_if.rvalid = 1'b0; out_if.rdata = 32'h0; out_if.rresp = 2'b00;
    endtask

    function automatic logic [34:0] rd_obs(input logic m);
        rd_obs = m ? {lsu_if.rvalid, lsu_if.rdata, lsu_if.rresp}
                   : {ifu_if.rvalid, ifu_if.rdata, ifu_if.rresp};
    endfunction

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        smp();
        checks++;
        if ({out_if.arvalid, out_if.rready, ifu_if.arready, ifu_if.rvalid, lsu_if.arready,
             lsu_if.rvalid, out_if.araddr} !== {6'b010000, 32'h0}) begin
            errors++;
            $display("FAIL reset_outputs: got arv=%b rrdy=%b ifu_ar=%b ifu_rv=%b lsu_ar=%b lsu_rv=%b, want 0 1 0 0 0 0",
                     out_if.arvalid, out_if.rready, ifu_if.arready, ifu_if.rvalid, lsu_if.arready, lsu_if.rvalid);
        end
        rst_n = 1'b1;
        smp();
        checks++;
        if ({out_if.arvalid, out_if.rready, ifu_if.rvalid, lsu_if.rvalid} !== 4'b0100) begin
            errors++;
            $display("FAIL reset_release_idle: got %b want 0100",
                     {out_if.arvalid, out_if.rready, ifu_if.rvalid, lsu_if.rvalid});
        end
    endtask

    task automatic test_tie();
        logic        win;
        logic [31:0] win_addr;
        logic [31:0] lose_addr;
        exp_t        e;
`ifdef ARB_ROUND_ROBIN_EN
        win = 1'b0;
`else
        win = 1'b1;
`endif
        win_addr  = win ? 32'h8000_0010 : 32'h3000_0100;
        lose_addr = win ? 32'h3000_0100 : 32'h8000_0010;
        nxt();
        ifu_if.arvalid = 1'b1; ifu_if.araddr = 32'h3000_0100; ifu_if.arsize = 3'd2; ifu_if.rready = 1'b1;
        lsu_if.arvalid = 1'b1; lsu_if.araddr = 32'h8000_0010; lsu_if.arsize = 3'd2; lsu_if.rready = 1'b1;
        out_if.arready = 1'b1;
        sb_q.push_back('{m: win, data: 32'h1111_2222, resp: 2'b00});
        sb_q.push_back('{m: ~win, data: 32'h3333_4444, resp: 2'b00});
        nxt();
        smp();
        checks++;
        if ({out_if.araddr, lsu_if.arready, ifu_if.arready} !== {win_addr, win, ~win}) begin
            errors++;
            $display("FAIL tie_first_ar: got addr=%h lsu_ar=%b ifu_ar=%b want addr=%h",
                     out_if.araddr, lsu_if.arready, ifu_if.arready, win_addr);
        end
        nxt();
        if (win) lsu_if.arvalid = 1'b0;
        else     ifu_if.arvalid = 1'b0;
        out_if.arready = 1'b0; out_if.rvalid = 1'b1; out_if.rdata = 32'h1111_2222; out_if.rresp = 2'b00;
        smp();
        e = sb_q.pop_front();
        checks++;
        if (rd_obs(e.m) !== {1'b1, e.data, e.resp} || rd_obs(~e.m) !== 35'h0) begin
            errors++;
            $display("FAIL tie_first_r: got granted=%h other=%h want granted=%h other=0",
                     rd_obs(e.m), rd_obs(~e.m), {1'b1, e.data, e.resp});
        end
        nxt();
        out_if.rvalid = 1'b0; out_if.arready = 1'b1;
        smp();
        checks++;
        if ({ifu_if.arready, lsu_if.arready, out_if.arvalid} !== 3'b000) begin
            errors++;
            $display("FAIL tie_idle_gap: got %b want 000",
                     {ifu_if.arready, lsu_if.arready, out_if.arvalid});
        end
        nxt();
        smp();
        checks++;
        if ({out_if.araddr, lsu_if.arready, ifu_if.arready} !== {lose_addr, ~win, win}) begin
            errors++;
            $display("FAIL tie_second_ar: got addr=%h lsu_ar=%b ifu_ar=%b want addr=%h",
                     out_if.araddr, lsu_if.arready, ifu_if.arready, lose_addr);
        end
        nxt();
        ifu_if.arvalid = 1'b0; lsu_if.arvalid = 1'b0;
        out_if.arready = 1'b0; out_if.rvalid = 1'b1; out_if.rdata = 32'h3333_4444;
        smp();
        e = sb_q.pop_front();
        checks++;
        if (rd_obs(e.m) !== {1'b1, e.data, e.resp} || rd_obs(~e.m) !== 35'h0) begin
            errors++;
            $display("FAIL tie_second_r: got granted=%h other=%h want granted=%h other=0",
                     rd_obs(e.m), rd_obs(~e.m), {1'b1, e.data, e.resp});
        end
        nxt();
        clear_inputs();
    endtask

    task automatic test_ifu_only();
        exp_t e;
        nxt();
        ifu_if.arvalid = 1'b1; ifu_if.araddr = 32'h3000_0000; ifu_if.arsize = 3'd2; ifu_if.rready = 1'b1;
        out_if.arready = 1'b1;
        sb_q.push_back('{m: 1'b0, data: 32'hDEAD_BEEF, resp: 2'b00});
        smp();
        checks++;
        if ({ifu_if.arready, out_if.arvalid} !== 2'b00) begin
            errors++;
            $display("FAIL ifu_idle_no_arready: got %b want 00", {ifu_if.arready, out_if.arvalid});
        end
        nxt();
        smp();
        checks++;
        if ({out_if.arvalid, out_if.araddr, out_if.arsize, ifu_if.arready, lsu_if.arready} !==
            {1'b1, 32'h3000_0000, 3'd2, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL ifu_ar_pass: got arv=%b addr=%h size=%0d ifu_ar=%b lsu_ar=%b",
                     out_if.arvalid, out_if.araddr, out_if.arsize, ifu_if.arready, lsu_if.arready);
        end
        nxt();
        ifu_if.arvalid = 1'b0; out_if.arready = 1'b0;
        nxt();
        smp();
        checks++;
        if ({ifu_if.rvalid, out_if.rready} !== 2'b01) begin
            errors++;
            $display("FAIL ifu_r_wait: got rvalid=%b out_rready=%b want 0 1", ifu_if.rvalid, out_if.rready);
        end
        nxt();
        out_if.rvalid = 1'b1; out_if.rdata = 32'hDEAD_BEEF; out_if.rresp = 2'b00;
        smp();
        e = sb_q.pop_front();
        checks++;
        if (rd_obs(e.m) !== {1'b1, e.data, e.resp} || rd_obs(~e.m) !== 35'h0) begin
            errors++;
            $display("FAIL ifu_rdata: got ifu=%h lsu=%h want ifu=%h lsu=0",
                     rd_obs(e.m), rd_obs(~e.m), {1'b1, e.data, e.resp});
        end
        nxt();
        clear_inputs();
        smp();
        checks++;
        if ({out_if.rready, ifu_if.rvalid, lsu_if.rvalid} !== 3'b100) begin
            errors++;
            $display("FAIL ifu_back_idle: got %b want 100", {out_if.rready, ifu_if.rvalid, lsu_if.rvalid});
        end
    endtask

    task automatic test_ar_stall();
        exp_t e;
        nxt();
        lsu_if.arvalid = 1'b1; lsu_if.araddr = 32'h8000_2000; lsu_if.arsize = 3'd1; lsu_if.rready = 1'b1;
        out_if.arready = 1'b0;
        sb_q.push_back('{m: 1'b1, data: 32'hCAFE_0001, resp: 2'b01});
        nxt();
        for (int i = 0; i < 5; i++) begin
            smp();
            checks++;
            if ({out_if.arvalid, out_if.araddr, out_if.arsize, lsu_if.arready, ifu_if.arready} !==
                {1'b1, 32'h8000_2000, 3'd1, 2'b00}) begin
                errors++;
                $display("FAIL ar_stall[%0d]: got arv=%b addr=%h size=%0d lsu_ar=%b ifu_ar=%b",
                         i, out_if.arvalid, out_if.araddr, out_if.arsize, lsu_if.arready, ifu_if.arready);
            end
            nxt();
        end
        out_if.arready = 1'b1;
        smp();
        checks++;
        if ({lsu_if.arready, out_if.arvalid} !== 2'b11) begin
            errors++;
            $display("FAIL ar_release: got lsu_ar=%b arv=%b want 1 1", lsu_if.arready, out_if.arvalid);
        end
        nxt();
        lsu_if.arvalid = 1'b0; out_if.arready = 1'b0;
        out_if.rvalid = 1'b1; out_if.rdata = 32'hCAFE_0001; out_if.rresp = 2'b01;
        smp();
        e = sb_q.pop_front();
        checks++;
        if (rd_obs(e.m) !== {1'b1, e.data, e.resp} || rd_obs(~e.m) !== 35'h0) begin
            errors++;
            $display("FAIL stall_r: got lsu=%h ifu=%h want lsu=%h ifu=0",
                     rd_obs(e.m), rd_obs(~e.m), {1'b1, e.data, e.resp});
        end
        nxt();
        clear_inputs();
    endtask

    task automatic test_rready_hold();
        exp_t e;
        nxt();
        ifu_if.arvalid = 1'b1; ifu_if.araddr = 32'h3000_0040; ifu_if.arsize = 3'd2; ifu_if.rready = 1'b0;
        out_if.arready = 1'b1;
        sb_q.push_back('{m: 1'b0, data: 32'h1234_5678, resp: 2'b00});
        nxt();
        nxt();
        ifu_if.arvalid = 1'b0; out_if.arready = 1'b0;
        out_if.rvalid = 1'b1; out_if.rdata = 32'h1234_5678; out_if.rresp = 2'b00;
        for (int i = 0; i < 3; i++) begin
            smp();
            checks++;
            if ({out_if.rready, ifu_if.rvalid, ifu_if.rdata} !== {1'b0, 1'b1, 32'h1234_5678}) begin
                errors++;
                $display("FAIL rready_hold[%0d]: got out_rready=%b rvalid=%b rdata=%h want 0 1 12345678",
                         i, out_if.rready, ifu_if.rvalid, ifu_if.rdata);
            end
            nxt();
        end
        ifu_if.rready = 1'b1;
        smp();
        e = sb_q.pop_front();
        checks++;
        if (out_if.rready !== 1'b1 || rd_obs(e.m) !== {1'b1, e.data, e.resp}) begin
            errors++;
            $display("FAIL rready_release: got out_rready=%b ifu=%h want 1 %h",
                     out_if.rready, rd_obs(e.m), {1'b1, e.data, e.resp});
        end
        nxt();
        clear_inputs();
        smp();
        checks++;
        if ({out_if.rready, ifu_if.rvalid} !== 2'b10) begin
            errors++;
            $display("FAIL rready_done_idle: got %b want 10", {out_if.rready, ifu_if.rvalid});
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int   k;
        nxt();
        lsu_if.arvalid = 1'b1; lsu_if.araddr = 32'h8000_3000; lsu_if.arsize = 3'd2; lsu_if.rready = 1'b0;
        out_if.arready = 1'b1;
        sb_q.push_back('{m: 1'b1, data: 32'h0, resp: 2'b11});
        nxt();
        nxt();
        lsu_if.arvalid = 1'b0; out_if.arready = 1'b0;
        k = 0;
        smp();
        while (lsu_if.rvalid !== 1'b1 && k < 20) begin
            nxt();
            k++;
            smp();
        end
        checks++;
        if (k !== 8) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles after R entry want 8", k);
        end
        checks++;
        if (out_if.rready !== 1'b0) begin
            errors++;
            $display("FAIL timeout_out_rready: got %b want 0", out_if.rready);
        end
        e = sb_q.pop_front();
        checks++;
        if (rd_obs(e.m) !== {1'b1, e.data, e.resp} || rd_obs(~e.m) !== 35'h0) begin
            errors++;
            $display("FAIL timeout_resp: got lsu=%h ifu=%h want lsu=%h ifu=0",
                     rd_obs(e.m), rd_obs(~e.m), {1'b1, e.data, e.resp});
        end
        nxt();
        smp();
        checks++;
        if ({lsu_if.rvalid, lsu_if.rresp} !== 3'b111) begin
            errors++;
            $display("FAIL timeout_hold: got rvalid=%b rresp=%b want 1 11", lsu_if.rvalid, lsu_if.rresp);
        end
        nxt();
        lsu_if.rready = 1'b1;
        nxt();
        lsu_if.rready = 1'b0;
        out_if.rvalid = 1'b1; out_if.rdata = 32'hBAD0_BAD0; out_if.rresp = 2'b00;
        smp();
        checks++;
        if ({out_if.rready, lsu_if.rvalid, ifu_if.rvalid} !== 3'b100) begin
            errors++;
            $display("FAIL late_beat_drop: got %b want 100", {out_if.rready, lsu_if.rvalid, ifu_if.rvalid});
        end
        nxt();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        nxt();
        ifu_if.arvalid = 1'b1; ifu_if.araddr = 32'h3000_0080; ifu_if.arsize = 3'd2; ifu_if.rready = 1'b0;
        out_if.arready = 1'b1;
        nxt();
        nxt();
        ifu_if.arvalid = 1'b0; out_if.arready = 1'b0;
        out_if.rvalid = 1'b1; out_if.rdata = 32'h5555_AAAA;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_if.arvalid, out_if.rready, ifu_if.arready, ifu_if.rvalid, lsu_if.arready, lsu_if.rvalid} !== 6'b010000) begin
            errors++;
            $display("FAIL reset_mid_async: got %b want 010000",
                     {out_if.arvalid, out_if.rready, ifu_if.arready, ifu_if.rvalid, lsu_if.arready, lsu_if.rvalid});
        end
        clear_inputs();
        smp();
        rst_n = 1'b1;
        nxt();
        lsu_if.arvalid = 1'b1; lsu_if.araddr = 32'h8000_0400; lsu_if.arsize = 3'd2; lsu_if.rready = 1'b1;
        out_if.arready = 1'b1;
        sb_q.push_back('{m: 1'b1, data: 32'h0BAD_F00D, resp: 2'b00});
        nxt();
        smp();
        checks++;
        if ({out_if.araddr, lsu_if.arready} !== {32'h8000_0400, 1'b1}) begin
            errors++;
            $display("FAIL after_reset_ar: got addr=%h lsu_ar=%b want 80000400 1", out_if.araddr, lsu_if.arready);
        end
        nxt();
        lsu_if.arvalid = 1'b0; out_if.arready = 1'b0;
        out_if.rvalid = 1'b1; out_if.rdata = 32'h0BAD_F00D; out_if.rresp = 2'b00;
        smp();
        e = sb_q.pop_front();
        checks++;
        if (rd_obs(e.m) !== {1'b1, e.data, e.resp} || rd_obs(~e.m) !== 35'h0) begin
            errors++;
            $display("FAIL after_reset_r: got lsu=%h ifu=%h want lsu=%h ifu=0",
                     rd_obs(e.m), rd_obs(~e.m), {1'b1, e.data, e.resp});
        end
        nxt();
        clear_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_tie();
        test_ifu_only();
        test_ar_stall();
        test_rready_hold();
        test_timeout();
        test_reset_mid();
        checks++;
        if (sb_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
